cardinal_nic: RTL and testbench

- Network interface controller between one PE (cardinal processor) and its local router port in the 4x4 mesh of the cardinal CMP.
- Exposes a 4-register memory-mapped interface to the PE and a ready/send handshake channel pair to the router.
- Holds one output channel buffer (PE to network) and one input channel buffer (network to PE), one 64-bit packet each.
- Injects packets only on the virtual channel phase selected by the mesh-wide polarity signal.

---
 rtl/cardinal_nic_if.sv | 31 +++
 rtl/cardinal_nic.sv | 90 +++++++++
 tb/tb_cardinal_nic.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cardinal_nic_if.sv
// PE register bus and router channel pair for the cardinal NIC.
// slave is the NIC side; master is the PE/router side.
interface cardinal_nic_if #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 2
);
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] d_in;
    logic [DATA_WIDTH-1:0] d_out;
    logic                  nicEn;
    logic                  nicWrEn;
    logic                  net_so;
    logic                  net_ro;
    logic [DATA_WIDTH-1:0] net_do;
    logic                  net_polarity;
    logic                  net_si;
    logic                  net_ri;
    logic [DATA_WIDTH-1:0] net_di;

    modport slave (
        input  addr, d_in, nicEn, nicWrEn,
        input  net_ro, net_polarity, net_si, net_di,
        output d_out, net_so, net_do, net_ri
    );

    modport master (
        output addr, d_in, nicEn, nicWrEn,
        output net_ro, net_polarity, net_si, net_di,
        input  d_out, net_so, net_do, net_ri
    );
endinterface

// File: rtl/cardinal_nic.sv
// Cardinal NIC: one-packet output and input buffers between a PE
// and its mesh router port, injecting only on the matching VC phase.
module cardinal_nic #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 2
) (
    input logic           clk,
    input logic           reset,
    cardinal_nic_if.slave bus
);
    localparam logic [1:0] A_IBUF = 2'b00;
    localparam logic [1:0] A_ISTS = 2'b01;
    localparam logic [1:0] A_OBUF = 2'b10;
    localparam logic [1:0] A_OSTS = 2'b11;

    logic [DATA_WIDTH-1:0] obuf_q, obuf_d;
    logic [DATA_WIDTH-1:0] ibuf_q, ibuf_d;
    logic                  obuf_full_q, obuf_full_d;
    logic                  ibuf_full_q, ibuf_full_d;

    logic                  pe_wr;
    logic                  pe_rd;
    logic                  send;
    logic [1:0]            sel;
    logic [DATA_WIDTH-1:0] d_out_c;

    assign sel   = 2'(bus.addr);
    assign pe_wr = bus.nicEn & bus.nicWrEn;
    assign pe_rd = bus.nicEn & ~bus.nicWrEn;

    // Gated by reset so a buffered packet is never sent in a reset cycle.
    assign send = reset & obuf_full_q & bus.net_ro
                & (obuf_q[DATA_WIDTH-1] == bus.net_polarity);

    assign bus.net_so = send;
    assign bus.net_do = obuf_q;
    assign bus.net_ri = ~ibuf_full_q;
    assign bus.d_out  = d_out_c;

    always_comb begin
        obuf_d      = obuf_q;
        obuf_full_d = obuf_full_q;
        ibuf_d      = ibuf_q;
        ibuf_full_d = ibuf_full_q;

        if (send) begin
            obuf_full_d = 1'b0;
        end
        // A write is only accepted into an empty buffer, so it never races a send.
        if (pe_wr && sel == A_OBUF && !obuf_full_q) begin
            obuf_d      = bus.d_in;
            obuf_full_d = 1'b1;
        end

        if (bus.net_si && !ibuf_full_q) begin
            ibuf_d      = bus.net_di;
            ibuf_full_d = 1'b1;
        end
        if (pe_rd && sel == A_IBUF && ibuf_full_q) begin
            ibuf_full_d = 1'b0;
        end
    end

    always_comb begin
        d_out_c = '0;
        if (pe_rd) begin
            unique case (sel)
                A_IBUF: d_out_c = ibuf_q;
                A_ISTS: d_out_c = {{(DATA_WIDTH-1){1'b0}}, ibuf_full_q};
                A_OBUF: d_out_c = '0;
                A_OSTS: d_out_c = {{(DATA_WIDTH-1){1'b0}}, obuf_full_q};
                default: d_out_c = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            obuf_q      <= '0;
            obuf_full_q <= 1'b0;
            ibuf_q      <= '0;
            ibuf_full_q <= 1'b0;
        end else begin
            obuf_q      <= obuf_d;
            obuf_full_q <= obuf_full_d;
            ibuf_q      <= ibuf_d;
            ibuf_full_q <= ibuf_full_d;
        end
    end
endmodule

// File: tb/tb_cardinal_nic.sv
// Directed bench for cardinal_nic: inputs change on the falling edge,
// outputs are compared 1ns later, well clear of the rising edge.
module tb_cardinal_nic;
    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;

    cardinal_nic_if #(.DATA_WIDTH(64), .ADDR_WIDTH(2)) bus ();

    cardinal_nic #(.DATA_WIDTH(64), .ADDR_WIDTH(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle;
        bus.nicEn        = 1'b0;
        bus.nicWrEn      = 1'b0;
        bus.addr         = 2'b00;
        bus.d_in         = '0;
        bus.net_si       = 1'b0;
        bus.net_di       = '0;
        bus.net_ro       = 1'b0;
        bus.net_polarity = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a);
        bus.nicEn   = 1'b1;
        bus.nicWrEn = 1'b0;
        bus.addr    = a;
    endtask

    task automatic wr(input logic [1:0] a, input logic [63:0] d);
        bus.nicEn   = 1'b1;
        bus.nicWrEn = 1'b1;
        bus.addr    = a;
        bus.d_in    = d;
    endtask

    task automatic test_reset;
        #1;
        vectors++;
        if (bus.net_so !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_so got %0b want 0", bus.net_so);
        end
        vectors++;
        if (bus.net_ri !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_ri got %0b want 1", bus.net_ri);
        end
        vectors++;
        if (bus.net_do !== 64'h0) begin
            miscompares++;
            $display("FAIL rst_do got %h want 0", bus.net_do);
        end
        tick();
        #1;
        vectors++;
        if (bus.net_so !== 1'b0 || bus.net_ri !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_hold so=%0b ri=%0b want 0/1", bus.net_so, bus.net_ri);
        end
        reset = 1'b1;
        idle();
        rd(2'b01);
        #1;
        vectors++;
        if (bus.d_out !== 64'h0) begin
            miscompares++;
            $display("FAIL rst_ists got %h want 0", bus.d_out);
        end
        rd(2'b11);
        #1;
        vectors++;
        if (bus.d_out !== 64'h0) begin
            miscompares++;
            $display("FAIL rst_osts got %h want 0", bus.d_out);
        end
        rd(2'b00);
        #1;
        vectors++;
        if (bus.d_out !== 64'h0) begin
            miscompares++;
            $display("FAIL rst_ibuf got %h want 0", bus.d_out);
        end
        idle();
        tick();
    endtask

    task automatic test_injection;
        idle();
        wr(2'b10, 64'h8000_0000_0000_00AA);
        bus.net_ro       = 1'b1;
        bus.net_polarity = 1'b0;
        #1;
        vectors++;
        if (bus.net_so !== 1'b0) begin
            miscompares++;
            $display("FAIL inj_wrcyc got %0b want 0", bus.net_so);
        end
        tick();
        for (int i = 0; i < 3; i++) begin
            rd(2'b11);
            #1;
            vectors++;
            if (bus.net_so !== 1'b0 || bus.d_out !== 64'h1) begin
                miscompares++;
                $display("FAIL inj_hold%0d so=%0b sts=%h want 0/1", i, bus.net_so, bus.d_out);
            end
            tick();
        end
        bus.net_polarity = 1'b1;
        #1;
        vectors++;
        if (bus.net_so !== 1'b1 || bus.net_do !== 64'h8000_0000_0000_00AA) begin
            miscompares++;
            $display("FAIL inj_send so=%0b do=%h want 1/80000000000000aa", bus.net_so, bus.net_do);
        end
        tick();
        #1;
        vectors++;
        if (bus.net_so !== 1'b0 || bus.d_out !== 64'h0) begin
            miscompares++;
            $display("FAIL inj_once so=%0b sts=%h want 0/0", bus.net_so, bus.d_out);
        end
        idle();
        tick();
    endtask

    task automatic test_backpressure;
        idle();
        bus.net_polarity = 1'b1;
        wr(2'b10, 64'h11);
        tick();
        wr(2'b10, 64'h22);
        #1;
        vectors++;
        if (bus.net_so !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_noro got %0b want 0", bus.net_so);
        end
        tick();
        rd(2'b11);
        #1;
        vectors++;
        if (bus.d_out !== 64'h1 || bus.net_do !== 64'h11) begin
            miscompares++;
            $display("FAIL bp_full sts=%h do=%h want 1/11", bus.d_out, bus.net_do);
        end
        bus.net_ro       = 1'b1;
        bus.net_polarity = 1'b0;
        #1;
        vectors++;
        if (bus.net_so !== 1'b1 || bus.net_do !== 64'h11) begin
            miscompares++;
            $display("FAIL bp_send so=%0b do=%h want 1/11", bus.net_so, bus.net_do);
        end
        tick();
        #1;
        vectors++;
        if (bus.net_so !== 1'b0 || bus.d_out !== 64'h0 || bus.net_do !== 64'h11) begin
            miscompares++;
            $display("FAIL bp_drop so=%0b sts=%h do=%h want 0/0/11", bus.net_so, bus.d_out, bus.net_do);
        end
        tick();
        #1;
        vectors++;
        if (bus.net_so !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_after got %0b want 0", bus.net_so);
        end
        idle();
        tick();
    endtask

    task automatic test_receive;
        idle();
        bus.net_si = 1'b1;
        bus.net_di = 64'h1234;
        #1;
        vectors++;
        if (bus.net_ri !== 1'b1) begin
            miscompares++;
            $display("FAIL rx_ri0 got %0b want 1", bus.net_ri);
        end
        tick();
        bus.net_si = 1'b0;
        rd(2'b01);
        #1;
        vectors++;
        if (bus.net_ri !== 1'b0 || bus.d_out !== 64'h1) begin
            miscompares++;
            $display("FAIL rx_full ri=%0b sts=%h want 0/1", bus.net_ri, bus.d_out);
        end
        rd(2'b00);
        #1;
        vectors++;
        if (bus.d_out !== 64'h1234) begin
            miscompares++;
            $display("FAIL rx_read got %h want 1234", bus.d_out);
        end
        tick();
        rd(2'b01);
        #1;
        vectors++;
        if (bus.net_ri !== 1'b1 || bus.d_out !== 64'h0) begin
            miscompares++;
            $display("FAIL rx_freed ri=%0b sts=%h want 1/0", bus.net_ri, bus.d_out);
        end
        rd(2'b00);
        #1;
        vectors++;
        if (bus.d_out !== 64'h1234) begin
            miscompares++;
            $display("FAIL rx_stale got %h want 1234", bus.d_out);
        end
        tick();
        rd(2'b01);
        #1;
        vectors++;
        if (bus.d_out !== 64'h0) begin
            miscompares++;
            $display("FAIL rx_stale_sts got %h want 0", bus.d_out);
        end
        idle();
        tick();
    endtask

    task automatic test_overflow;
        idle();
        bus.net_si = 1'b1;
        bus.net_di = 64'h1234;
        tick();
        bus.net_di = 64'h5678;
        #1;
        vectors++;
        if (bus.net_ri !== 1'b0) begin
            miscompares++;
            $display("FAIL ovf_ri got %0b want 0", bus.net_ri);
        end
        tick();
        bus.net_si = 1'b0;
        rd(2'b00);
        #1;
        vectors++;
        if (bus.d_out !== 64'h1234) begin
            miscompares++;
            $display("FAIL ovf_keep got %h want 1234", bus.d_out);
        end
        tick();
        idle();
        #1;
        vectors++;
        if (bus.net_ri !== 1'b1) begin
            miscompares++;
            $display("FAIL ovf_free got %0b want 1", bus.net_ri);
        end
        tick();
    endtask

    task automatic test_concurrency;
        idle();
        wr(2'b10, 64'h8000_0000_0000_0C0D);
        tick();
        bus.net_ro       = 1'b1;
        bus.net_polarity = 1'b1;
        bus.net_si       = 1'b1;
        bus.net_di       = 64'hBEEF;
        wr(2'b10, 64'h33);
        #1;
        vectors++;
        if (bus.net_so !== 1'b1 || bus.net_ri !== 1'b1) begin
            miscompares++;
            $display("FAIL cc_both so=%0b ri=%0b want 1/1", bus.net_so, bus.net_ri);
        end
        tick();
        idle();
        rd(2'b11);
        #1;
        vectors++;
        if (bus.d_out !== 64'h0 || bus.net_do !== 64'h8000_0000_0000_0C0D) begin
            miscompares++;
            $display("FAIL cc_osts sts=%h do=%h want 0/8000000000000c0d", bus.d_out, bus.net_do);
        end
        rd(2'b01);
        #1;
        vectors++;
        if (bus.d_out !== 64'h1) begin
            miscompares++;
            $display("FAIL cc_ists got %h want 1", bus.d_out);
        end
        rd(2'b00);
        #1;
        vectors++;
        if (bus.d_out !== 64'hBEEF) begin
            miscompares++;
            $display("FAIL cc_ibuf got %h want beef", bus.d_out);
        end
        tick();
        idle();
        tick();
    endtask

    task automatic test_misc_access;
        idle();
        bus.net_si = 1'b1;
        bus.net_di = 64'h77;
        tick();
        idle();
        wr(2'b00, 64'hFFFF);
        tick();
        wr(2'b01, 64'hFFFF);
        tick();
        wr(2'b11, 64'hFFFF);
        tick();
        bus.nicEn = 1'b0;
        bus.addr  = 2'b00;
        #1;
        vectors++;
        if (bus.d_out !== 64'h0) begin
            miscompares++;
            $display("FAIL misc_dis got %h want 0", bus.d_out);
        end
        tick();
        rd(2'b10);
        #1;
        vectors++;
        if (bus.d_out !== 64'h0) begin
            miscompares++;
            $display("FAIL misc_rd10 got %h want 0", bus.d_out);
        end
        rd(2'b11);
        #1;
        vectors++;
        if (bus.d_out !== 64'h0) begin
            miscompares++;
            $display("FAIL misc_osts got %h want 0", bus.d_out);
        end
        rd(2'b01);
        #1;
        vectors++;
        if (bus.d_out !== 64'h1) begin
            miscompares++;
            $display("FAIL misc_ists got %h want 1", bus.d_out);
        end
        rd(2'b00);
        #1;
        vectors++;
        if (bus.d_out !== 64'h77) begin
            miscompares++;
            $display("FAIL misc_ibuf got %h want 77", bus.d_out);
        end
        idle();
    endtask

    task automatic test_reset_midflight;
        idle();
        wr(2'b10, 64'h8000_0000_0000_0099);
        tick();
        idle();
        reset            = 1'b0;
        bus.net_ro       = 1'b1;
        bus.net_polarity = 1'b1;
        #1;
        vectors++;
        if (bus.net_so !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_nosend got %0b want 0", bus.net_so);
        end
        tick();
        reset = 1'b1;
        #1;
        vectors++;
        if (bus.net_so !== 1'b0 || bus.net_ri !== 1'b1 || bus.net_do !== 64'h0) begin
            miscompares++;
            $display("FAIL mid_clr so=%0b ri=%0b do=%h want 0/1/0", bus.net_so, bus.net_ri, bus.net_do);
        end
        rd(2'b00);
        #1;
        vectors++;
        if (bus.d_out !== 64'h0) begin
            miscompares++;
            $display("FAIL mid_ibuf got %h want 0", bus.d_out);
        end
        idle();
        tick();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b0;
        bus.net_si       = 1'b1;
        bus.net_di       = 64'hDEAD;
        bus.nicEn        = 1'b1;
        bus.nicWrEn      = 1'b1;
        bus.addr         = 2'b10;
        bus.d_in         = 64'h8000_0000_0000_0001;
        bus.net_ro       = 1'b1;
        bus.net_polarity = 1'b1;
        @(negedge clk);
        test_reset();
        test_injection();
        test_backpressure();
        test_receive();
        test_overflow();
        test_concurrency();
        test_misc_access();
        test_reset_midflight();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
